// File: rtl/dmem_mmio_pkg.sv
// Shared constants and address decode for the MIPS data-side responder.
package dmem_mmio_pkg;

  localparam int DATA_W = 32;

  // Upper half-word that selects the memory-mapped I/O page.
  localparam logic [15:0] MMIO_PAGE = 16'hFFFF;

  localparam logic [DATA_W-1:0] MMIO_OUT_DATA = 32'hFFFF_0000;
  localparam logic [DATA_W-1:0] MMIO_OUT_STAT = 32'hFFFF_0004;
  localparam logic [DATA_W-1:0] MMIO_CYCLE    = 32'hFFFF_0008;
  localparam logic [DATA_W-1:0] MMIO_HALT     = 32'hFFFF_000C;

  // Target selected by a data-port address.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_OUT_DATA,
    SEL_OUT_STAT,
    SEL_CYCLE,
    SEL_HALT
  } sel_e;

  // Decode a word address (byte address with the two low bits dropped).
  function automatic sel_e decode_sel(input logic [DATA_W-1:2] wa);
    sel_e s;
    s = SEL_NONE;
    if (wa[DATA_W-1:16] == 16'h0000)              s = SEL_RAM;
    else if (wa == MMIO_OUT_DATA[DATA_W-1:2])     s = SEL_OUT_DATA;
    else if (wa == MMIO_OUT_STAT[DATA_W-1:2])     s = SEL_OUT_STAT;
    else if (wa == MMIO_CYCLE[DATA_W-1:2])        s = SEL_CYCLE;
    else if (wa == MMIO_HALT[DATA_W-1:2])         s = SEL_HALT;
    return s;
  endfunction

endpackage

// File: rtl/dmem_mmio_out_fifo.sv
// Byte FIFO feeding the host stream. The head byte is presented from
// registered state; a push into a full FIFO is only accepted when a pop
// frees a slot in the same cycle.
module out_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] count
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW+1)'(DEPTH);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  // Pop needs data present; push needs room, which a same-cycle pop provides.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next pointer/occupancy; pointers wrap naturally at FIFO_AW bits.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + FIFO_AW'(1);
    if (do_pop)  rptr_d = rptr_q + FIFO_AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards contents by clearing pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array carries no reset; stale bytes are unreachable after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus an
// MMIO page with a byte output stream, a free-running cycle counter and a
// sticky halt flag. Loads are combinational, stores commit at clk rise.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memwrite,
  output logic [DATA_W-1:0] readdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              halt
);

  sel_e              sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] ram_q [2**RAM_AW];

  logic              wr_ram, wr_out, wr_stat, wr_cycle, wr_halt;
  logic              fifo_pop;
  logic              fifo_empty, fifo_full;
  logic [FIFO_AW:0]  fifo_count;
  logic [7:0]        fifo_dout;
  logic [DATA_W-1:0] stat_word;

  logic              ovf_q, ovf_d;
  logic              halt_q, halt_d;
  logic [DATA_W-1:0] cycle_q, cycle_d;

  // Byte lanes are not supported, so the two low address bits play no part.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  assign sel     = decode_sel(addr[DATA_W-1:2]);
  assign ram_idx = addr[RAM_AW+1:2];

  assign wr_ram   = memwrite & (sel == SEL_RAM);
  assign wr_out   = memwrite & (sel == SEL_OUT_DATA);
  assign wr_stat  = memwrite & (sel == SEL_OUT_STAT);
  assign wr_cycle = memwrite & (sel == SEL_CYCLE);
  assign wr_halt  = memwrite & (sel == SEL_HALT);

  // The sink only consumes while a byte is actually presented.
  assign fifo_pop = tx_ready & ~fifo_empty;

  out_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_out),
    .din   (writedata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign tx_data  = fifo_dout;
  assign tx_valid = ~fifo_empty;
  assign halt     = halt_q;

  // Status word: occupancy right-aligned at bit 8, flags in the low bits.
  always_comb begin
    stat_word                = '0;
    stat_word[2:0]           = {ovf_q, fifo_full, fifo_empty};
    stat_word[FIFO_AW+8:8]   = fifo_count;
  end

  // Combinational load path from the decoded target's current state.
  always_comb begin
    readdata = '0;
    case (sel)
      SEL_RAM:      readdata = ram_q[ram_idx];
      SEL_OUT_STAT: readdata = stat_word;
      SEL_CYCLE:    readdata = cycle_q;
      SEL_HALT:     readdata = {{(DATA_W-1){1'b0}}, halt_q};
      default:      readdata = '0;
    endcase
  end

  // Next state for overflow flag, halt flag and cycle counter.
  always_comb begin
    ovf_d   = ovf_q;
    halt_d  = halt_q | wr_halt;
    cycle_d = wr_cycle ? writedata : cycle_q + 32'd1;
    // A dropped byte happens only when full and nothing leaves this cycle.
    if (wr_out && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wr_stat)                          ovf_d = 1'b0;
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      halt_q  <= 1'b0;
      cycle_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      halt_q  <= halt_d;
      cycle_q <= cycle_d;
    end
  end

  // RAM is never cleared; a store arriving while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (wr_ram && rst_n) ram_q[ram_idx] <= writedata;
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, output stream, overflow, counter, halt.
module tb_dmem_mmio;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;

  int n_vec;
  int n_err;

  localparam logic [31:0] A_OUT   = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE = 32'hFFFF_0008;
  localparam logic [31:0] A_HALT  = 32'hFFFF_000C;

  dmem_mmio #(
    .RAM_AW  (10),
    .FIFO_AW (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .readdata  (readdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .halt      (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Store one word: drives the strobe across exactly one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  // Combinational load, sampled 1 time unit after presenting the address.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; memwrite = 1'b0;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0; memwrite = 1'b0; tx_ready = 1'b0; addr = '0; writedata = '0;
    repeat (2) @(posedge clk); #1;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b want 0", halt); end
    rd(A_CYCLE, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_cycle got %h want 00000000", v); end
    rd(A_STAT, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL reset_stat got %h want 00000001", v); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rd(A_CYCLE, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL cycle_first_edge got %h want 00000001", v); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, v);
    n_vec++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_load got %h want deadbeef", v); end
    rd(32'h0000_1010, v);
    n_vec++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_alias got %h want deadbeef", v); end
    // Same-cycle read of the word being written sees the old contents.
    addr = 32'h0000_0010; writedata = 32'h1234_5678; memwrite = 1'b1; #1;
    n_vec++; if (readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_rd_during_wr got %h want deadbeef", readdata); end
    @(posedge clk); #1; memwrite = 1'b0;
    rd(32'h0000_0010, v);
    n_vec++; if (v !== 32'h1234_5678) begin n_err++; $display("FAIL ram_after_wr got %h want 12345678", v); end
    rd(32'h0001_0010, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL unmapped_rd got %h want 00000000", v); end
    rd(32'hFFFF_0010, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL mmio_hole_rd got %h want 00000000", v); end
    rd(A_OUT, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL out_data_rd got %h want 00000000", v); end
  endtask

  task automatic test_fifo_stream();
    logic [31:0] v;
    logic [7:0]  e;
    tx_ready = 1'b0;
    wr(A_OUT, 32'h0000_0041);
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_err++; $display("FAIL stream_first_head got %b/%h want 1/41", tx_valid, tx_data); end
    wr(A_OUT, 32'h0000_0042);
    wr(A_OUT, 32'h0000_0043);
    rd(A_STAT, v);
    n_vec++; if (v !== 32'h0000_0300) begin n_err++; $display("FAIL stream_stat3 got %h want 00000300", v); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = 8'h41 + 8'(i);
      n_vec++; if (tx_valid !== 1'b1 || tx_data !== e) begin n_err++; $display("FAIL stream_byte%0d got %b/%h want 1/%h", i, tx_valid, tx_data, e); end
      @(posedge clk); #1;
    end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained got %b want 0", tx_valid); end
    tx_ready = 1'b0;
    rd(A_STAT, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL stream_stat_empty got %h want 00000001", v); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0]  e;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(A_OUT, 32'h60 + i);
    rd(A_STAT, v);
    n_vec++; if (v !== 32'h0000_0806) begin n_err++; $display("FAIL ovf_stat got %h want 00000806", v); end
    wr(A_STAT, 32'h0);
    rd(A_STAT, v);
    n_vec++; if (v !== 32'h0000_0802) begin n_err++; $display("FAIL ovf_clear got %h want 00000802", v); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = 8'h60 + 8'(i);
      n_vec++; if (tx_valid !== 1'b1 || tx_data !== e) begin n_err++; $display("FAIL ovf_byte%0d got %b/%h want 1/%h", i, tx_valid, tx_data, e); end
      @(posedge clk); #1;
    end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_ninth_absent got valid=%b data=%h want valid 0", tx_valid, tx_data); end
    tx_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [31:0] v;
    logic [7:0]  e;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_OUT, 32'h70 + i);
    rd(A_STAT, v);
    n_vec++; if (v !== 32'h0000_0802) begin n_err++; $display("FAIL fullpop_pre got %h want 00000802", v); end
    tx_ready = 1'b1;
    wr(A_OUT, 32'h0000_0055);
    rd(A_STAT, v);
    n_vec++; if (v !== 32'h0000_0802) begin n_err++; $display("FAIL fullpop_count got %h want 00000802", v); end
    for (int i = 0; i < 8; i++) begin
      e = (i == 7) ? 8'h55 : 8'h71 + 8'(i);
      n_vec++; if (tx_valid !== 1'b1 || tx_data !== e) begin n_err++; $display("FAIL fullpop_byte%0d got %b/%h want 1/%h", i, tx_valid, tx_data, e); end
      @(posedge clk); #1;
    end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_drained got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_counter();
    logic [31:0] v;
    wr(A_CYCLE, 32'hFFFF_FFFE);
    rd(A_CYCLE, v);
    n_vec++; if (v !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL cycle_load got %h want fffffffe", v); end
    @(posedge clk); #1;
    rd(A_CYCLE, v);
    n_vec++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cycle_inc got %h want ffffffff", v); end
    @(posedge clk); #1;
    rd(A_CYCLE, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL cycle_wrap got %h want 00000000", v); end
  endtask

  task automatic test_halt_reset();
    logic [31:0] v;
    wr(32'h0000_0020, 32'hCAFE_F00D);
    n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL halt_pre got %b want 0", halt); end
    wr(A_HALT, 32'h0);
    n_vec++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_set got %b want 1", halt); end
    rd(A_HALT, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL halt_rd got %h want 00000001", v); end
    tx_ready = 1'b0;
    wr(A_OUT, 32'h31);
    wr(A_OUT, 32'h32);
    n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL halt_fifo2 got %b want 1", tx_valid); end
    #3; rst_n = 1'b0; #1;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL rst_halt got %b want 0", halt); end
    rd(A_CYCLE, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_cycle got %h want 00000000", v); end
    // Store presented while reset is held must be lost.
    addr = 32'h0000_0020; writedata = 32'h0000_0BAD; memwrite = 1'b1;
    @(posedge clk); #1; memwrite = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h0000_0020, v);
    n_vec++; if (v !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rst_ram_20 got %h want cafef00d", v); end
    rd(32'h0000_0010, v);
    n_vec++; if (v !== 32'h1234_5678) begin n_err++; $display("FAIL rst_ram_10 got %h want 12345678", v); end
    rd(A_STAT, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL rst_stat got %h want 00000001", v); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_ram();
    test_fifo_stream();
    test_overflow();
    test_full_pop();
    test_counter();
    test_halt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side responder for the single-cycle MIPS core: it answers the core's `aluresult` / `writedata` / `memwrite` / `readdata` data-memory port. It contains a word RAM, a small memory-mapped I/O page, a byte output FIFO streamed to the host or bench, a 32-bit cycle counter and a sticky halt flag. Reads are combinational so `lw` completes in the core's single cycle. Writes commit on the rising clock edge.

## Interface
- `RAM_AW`, default 10: RAM address width in words, giving 2^RAM_AW words.
- `FIFO_AW`, default 3: output FIFO depth is 2^FIFO_AW bytes.
- `clk` input, 1 bit: single clock, all state on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `addr` input, `DATA_W` bits: byte address from the core's `aluresult`. `addr[1:0]` is ignored; all accesses are whole words.
- `writedata` input, `DATA_W` bits: store data.
- `memwrite` input, 1 bit: store strobe, sampled at `clk` rise.
- `readdata` output, `DATA_W` bits: load data, combinational from `addr`.
- `tx_data` output, 8 bits: head byte of the FIFO.
- `tx_valid` output, 1 bit: FIFO is non-empty.
- `tx_ready` input, 1 bit: sink accepts `tx_data` when `tx_valid & tx_ready` at a `clk` rise.
- `halt` output, 1 bit: sticky program-end flag.

## Operation
Address decode:
- **RAM**: `addr[31:16]==0`. Word index is `addr[RAM_AW+1:2]`. Upper address bits inside the window alias.
- **OUT_DATA** `0xFFFF0000`:
  - Write pushes `writedata[7:0]`.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and `ovf` is set.
  - Reads return 0.
- **OUT_STAT** `0xFFFF0004`:
  - Read returns `{count, 5'b0, ovf, full, empty}`, with `count` right-aligned in bits [FIFO_AW+8:8] and zero-filled above.
  - Any write clears `ovf`.
- **CYCLE** `0xFFFF0008`:
  - Read returns the counter.
  - Write loads `writedata`; in that cycle the counter loads and does not increment.
- **HALT** `0xFFFF000C`:
  - Write of any value sets `halt`; it clears only on reset.
  - Read returns `{31'b0, halt}`.
- Any other address: reads return 0, writes are ignored.

FIFO behaviour:
- Push and pop in the same cycle: both take effect and `count` is unchanged. This also holds when full, so the push is accepted.
- Pointers wrap modulo 2^FIFO_AW.
- `count` is FIFO_AW+1 bits wide and ranges 0 to 2^FIFO_AW.

Cycle counter:
- Increments every cycle.
- Wraps from `0xFFFFFFFF` to `0`.

## Timing
- Reset values:
  - `tx_valid=0`, `halt=0`, counter `0`, `ovf=0`, FIFO empty with pointers 0.
  - `readdata` follows its decode.
  - RAM contents are not reset and are retained across reset.
- Load latency is 0 cycles: `readdata` is combinational on `addr` and the current state.
- A RAM read in the same cycle as a write to that word returns the old value.
- Store latency is 1 edge: the write is visible to reads after the rising edge.
- `tx_valid` and `tx_data` are registered state, not combinational from the current store. A byte pushed at edge N is presented from edge N onward.
- STAT reads reflect pre-edge state.
- Reset asserted mid-operation:
  - FIFO contents are discarded and `tx_valid` drops immediately (asynchronous).
  - An in-flight store is lost.
- `tx_ready` is ignored while `tx_valid=0`.

## Structure
- In the shared `def.h`:
  - MMIO constants `MMIO_OUT_DATA`, `MMIO_OUT_STAT`, `MMIO_CYCLE`, `MMIO_HALT`.
  - `MMIO_PAGE` = `16'hFFFF`.
  - Reuse `DATA_W`.
- One sub-module, `out_fifo`:
  - Parameterised by `FIFO_AW`.
  - Ports `push`, `din`, `pop`, `dout`, `empty`, `full`, `count`.
  - Asynchronous active-low reset.
- RAM, decode, counter and halt logic live in `dmem_mmio` itself.

## Test plan
- **RAM store/load**:
  - Stimulus: write `0xDEADBEEF` to `0x00000010`, then read `0x00000010`; read `0x00001010` with RAM_AW=10.
  - Required: `0x00000010` reads `0xDEADBEEF`; `0x00001010` also reads `0xDEADBEEF` (alias).
- **FIFO stream**:
  - Stimulus: `tx_ready=0`; write `0x41`, `0x42`, `0x43` to OUT_DATA; then `tx_ready=1`.
  - Required: before draining, STAT reads `count=3, empty=0`; bytes emerge in order `41, 42, 43` on consecutive cycles; `tx_valid` then drops and STAT bit0 = 1.
- **Overflow**:
  - Stimulus: `tx_ready=0`; perform 9 pushes with FIFO_AW=3; then write OUT_STAT.
  - Required: after the pushes, STAT reads `count=8, full=1, ovf=1` and the 9th byte is absent from the stream; after the STAT write, `ovf=0`.
- **Full with simultaneous pop**:
  - Stimulus: FIFO full, `tx_ready=1`, push `0x55`.
  - Required: `count` stays 8 and `0x55` is last out.
- **Counter**:
  - Stimulus: write `0xFFFFFFFE` to CYCLE.
  - Required: reads on the following cycles return `FFFFFFFE`, `FFFFFFFF`, `0`.
- **Halt and reset**:
  - Stimulus: write HALT; then pulse `rst_n` low mid-cycle with the FIFO holding 2 bytes.
  - Required: `halt=1` after the edge; on reset, `tx_valid=0`, `halt=0` and the counter reads `0` immediately; previously written RAM data is intact.
